avalon_st_packet_arbiter: RTL and testbench
===========================================

Name: avalon_st_packet_arbiter

Overview:
Packet-level round-robin arbiter that shares one Avalon-ST output channel between NUM_SOURCES Avalon-ST input channels.
- Sits downstream of per-source avalon_enforcer instances, so inputs are well-formed: sop-delimited, empty valid only on eop.
- Once a source is granted, its whole packet passes through unbroken.
- A watchdog releases a stalled grant.

Parameters:
NUM_SOURCES, 4, number of input channels (2..16).
DATA_WIDTH_IN_BYTES, 16, data width of every channel in bytes; the width of empty follows avalon_st_if.
TIMEOUT_CYCLES, 1024, cycles in LOCKED with no accepted beat before forced release; 0 disables the watchdog.

Ports:
clk  input  1  clock.
rst  input  1  reset; synchronous, active-high.
in_msg  avalon_st_if.slave  array [NUM_SOURCES]  requesting channels.
out_msg  avalon_st_if.master  1 channel  arbitrated output.
grant_idx  output  $clog2(NUM_SOURCES)  index of the current or last granted source.
busy  output  1  high while in LOCKED.
timeout_indi  output  1  one-cycle pulse on watchdog release.

Behaviour:
- Reset is synchronous and active-high. When rst=1 at a clk edge:
  - state <= IDLE, rr_ptr <= 0, grant_idx <= 0, wd_cnt <= 0, timeout_indi <= 0.
  - Since state is IDLE, out_msg.valid=0, busy=0, and all in_msg[i].rdy=0.
- State machine: IDLE and LOCKED.
- IDLE:
  - req[i] = in_msg[i].valid & in_msg[i].sop.
  - Pick the first set req scanning from rr_ptr upward, wrapping modulo NUM_SOURCES.
  - If any req is set: grant_idx <= pick, state <= LOCKED, wd_cnt <= 0.
  - No transfer happens in IDLE: all rdy=0 and out_msg.valid=0.
  - Valid beats without sop are not requests and stall; they are never dropped.
- LOCKED, with g = grant_idx:
  - out_msg.{valid,sop,eop,empty,data} = in_msg[g].{...}, combinational.
  - in_msg[g].rdy = out_msg.rdy; all other rdy = 0.
  - busy=1.
- Beat accepted = in_msg[g].valid & out_msg.rdy.
- Accepted beat with eop: state <= IDLE, rr_ptr <= (g+1) mod NUM_SOURCES. This includes single-beat sop&eop packets.
- Latency:
  - The first beat reaches out_msg 1 cycle after sop is first presented, provided the source wins arbitration.
  - Following beats pass through with zero latency.
  - Minimum gap between packets is 1 idle cycle, the arbitration cycle.
- Round robin:
  - A source that just finished gets lowest priority.
  - With all sources requesting continuously, grants rotate 0,1,2,3,0...
  - rr_ptr advances only on packet end or timeout, never on grant.
- Watchdog (TIMEOUT_CYCLES>0):
  - In LOCKED, wd_cnt increments each cycle with no accepted beat and clears on any accepted beat.
  - When wd_cnt == TIMEOUT_CYCLES-1 and no beat is accepted that cycle:
    - state <= IDLE, rr_ptr <= (g+1) mod NUM_SOURCES.
    - timeout_indi <= 1 for exactly one cycle.
    - wd_cnt <= 0.
  - The released packet is truncated: no eop is emitted. Downstream enforcement handles this.
  - wd_cnt width is $clog2(TIMEOUT_CYCLES+1). Saturation cannot occur because the count resets on release.
- Simultaneous events:
  - If an eop beat is accepted in the same cycle the watchdog would fire, eop wins: normal release and no timeout_indi.
  - A sop seen on the granted source while LOCKED is forwarded unchanged. This block does not re-enforce.
- Reset mid-packet: immediate return to IDLE and the packet is abandoned. The output must show valid=0 in the cycle after the reset edge.
- out_msg.rdy held low in LOCKED: the source is stalled and the watchdog counts.

Decomposition:
- Package avalon_arbiter_pkg holds:
  - arb_state_t enum {IDLE, LOCKED}.
  - Function next_rr_idx(idx, n) for modulo increment.
- One sub-module: rr_priority_picker.
  - Parameter N.
  - Inputs req[N], ptr.
  - Outputs any_req, pick.
  - Purely combinational, rotate-and-priority-encode.
- The top module holds the FSM, grant register, watchdog and mux.

Test Plan:
- Reset, then a 3-beat packet on source 2 (sop on beat 0, eop with empty=5 on beat 2), out_msg.rdy=1 -> grant_idx=2 one cycle later; out_msg carries 3 beats identical to the input with empty=5 on eop; busy drops the cycle after eop; rr_ptr=3.
- All 4 sources send back-to-back 2-beat packets, rdy=1 -> grant order 0,1,2,3,0; 1 idle cycle between packets; no beat lost or reordered; non-granted rdy=0 throughout.
- Sources 1 and 3 request with rr_ptr=2 -> 3 granted first, then 1.
- Single-beat sop&eop packets on sources 0 and 1 -> each granted, forwarded and released. Output pattern is valid on cycles 1 and 3 after sop, assuming both requests are held from cycle 0.
- TIMEOUT_CYCLES=8: source 0 sends sop, then valid=0 forever -> after 8 stalled cycles timeout_indi pulses once; state returns to IDLE; pending source 1 granted next.
- rst asserted on beat 2 of a 5-beat packet -> next cycle out_msg.valid=0, busy=0, grant_idx=0; a fresh sop from source 0 is granted normally.

Source files
------------

// File: rtl/avalon_arbiter_pkg.sv
// Shared types and helpers for the Avalon-ST packet arbiter.
package avalon_arbiter_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  // Modulo-n increment of a source index.
  function automatic int unsigned next_rr_idx(input int unsigned idx, input int unsigned n);
    return (idx + 32'd1 >= n) ? 32'd0 : idx + 32'd1;
  endfunction

endpackage

// File: rtl/avalon_st_if.sv
// Avalon-ST channel with ready/valid handshake and sop/eop/empty framing.
interface avalon_st_if #(
  parameter int unsigned DATA_WIDTH_IN_BYTES = 16
);
  localparam int unsigned EMPTY_W = (DATA_WIDTH_IN_BYTES > 1) ? $clog2(DATA_WIDTH_IN_BYTES) : 1;
  localparam int unsigned DATA_W  = 8 * DATA_WIDTH_IN_BYTES;

  logic               valid;
  logic               rdy;
  logic               sop;
  logic               eop;
  logic [EMPTY_W-1:0] empty;
  logic [DATA_W-1:0]  data;

  modport master (output valid, sop, eop, empty, data, input rdy);
  modport slave  (input valid, sop, eop, empty, data, output rdy);
endinterface

// File: rtl/rr_priority_picker.sv
// Round-robin pick: rotate requests so ptr is at bit 0, take the lowest set bit.
module rr_priority_picker #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic                 any_req,
  output logic [$clog2(N)-1:0] pick
);
  localparam int unsigned IW = $clog2(N);

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  int unsigned    off;
  int unsigned    sum;

  always_comb begin
    dbl     = {req, req} >> ptr;
    rot     = dbl[N-1:0];
    any_req = |rot;
    off     = 32'd0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) off = 32'(k);
    end
    sum = 32'(ptr) + off;
    if (sum >= N) sum = sum - N;
    pick = IW'(sum);
  end

endmodule

// File: rtl/avalon_st_packet_arbiter.sv
// Packet-level round-robin arbiter: N Avalon-ST sources onto one output, with stall watchdog.
module avalon_st_packet_arbiter
  import avalon_arbiter_pkg::*;
#(
  parameter int unsigned NUM_SOURCES         = 4,
  parameter int unsigned DATA_WIDTH_IN_BYTES = 16,
  parameter int unsigned TIMEOUT_CYCLES      = 1024
) (
  input  logic                           clk,
  input  logic                           rst,
  avalon_st_if.slave                     in_msg [NUM_SOURCES],
  avalon_st_if.master                    out_msg,
  output logic [$clog2(NUM_SOURCES)-1:0] grant_idx,
  output logic                           busy,
  output logic                           timeout_indi
);
  localparam int unsigned IDX_W   = $clog2(NUM_SOURCES);
  localparam int unsigned EMPTY_W = (DATA_WIDTH_IN_BYTES > 1) ? $clog2(DATA_WIDTH_IN_BYTES) : 1;
  localparam int unsigned DATA_W  = 8 * DATA_WIDTH_IN_BYTES;
  localparam int unsigned WD_W    = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  logic [NUM_SOURCES-1:0] in_valid, in_sop, in_eop, req, rdy_c;
  logic [EMPTY_W-1:0]     in_empty [NUM_SOURCES];
  logic [DATA_W-1:0]      in_data  [NUM_SOURCES];

  // Flatten the interface array so the grant register can index it.
  for (genvar gi = 0; gi < NUM_SOURCES; gi++) begin : g_src
    assign in_valid[gi]    = in_msg[gi].valid;
    assign in_sop[gi]      = in_msg[gi].sop;
    assign in_eop[gi]      = in_msg[gi].eop;
    assign in_empty[gi]    = in_msg[gi].empty;
    assign in_data[gi]     = in_msg[gi].data;
    assign in_msg[gi].rdy  = rdy_c[gi];
  end

  arb_state_t       state_q, state_d;
  logic [IDX_W-1:0] grant_q, grant_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [WD_W-1:0]  wd_cnt_q, wd_cnt_d;
  logic             timeout_q, timeout_d;
  logic             any_req;
  logic [IDX_W-1:0] pick;
  logic             locked_c, accept_c, wd_fire_c;

  assign req = in_valid & in_sop;

  rr_priority_picker #(.N(NUM_SOURCES)) u_picker (
    .req     (req),
    .ptr     (rr_ptr_q),
    .any_req (any_req),
    .pick    (pick)
  );

  assign locked_c  = (state_q == LOCKED);
  assign accept_c  = locked_c & in_valid[grant_q] & out_msg.rdy;
  assign wd_fire_c = (TIMEOUT_CYCLES != 0) && (wd_cnt_q == WD_LAST) && !accept_c;

  // Zero-latency pass-through of the granted source.
  assign out_msg.valid = locked_c & in_valid[grant_q];
  assign out_msg.sop   = in_sop[grant_q];
  assign out_msg.eop   = in_eop[grant_q];
  assign out_msg.empty = in_empty[grant_q];
  assign out_msg.data  = in_data[grant_q];

  always_comb begin
    rdy_c = '0;
    if (locked_c) rdy_c[grant_q] = out_msg.rdy;
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    rr_ptr_d  = rr_ptr_q;
    wd_cnt_d  = wd_cnt_q;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d  = LOCKED;
          grant_d  = pick;
          wd_cnt_d = '0;
        end
      end
      LOCKED: begin
        if (accept_c) begin
          wd_cnt_d = '0;
          if (in_eop[grant_q]) begin
            state_d  = IDLE;
            rr_ptr_d = IDX_W'(next_rr_idx(32'(grant_q), NUM_SOURCES));
          end
        end else if (wd_fire_c) begin
          state_d   = IDLE;
          rr_ptr_d  = IDX_W'(next_rr_idx(32'(grant_q), NUM_SOURCES));
          timeout_d = 1'b1;
          wd_cnt_d  = '0;
        end else begin
          wd_cnt_d = wd_cnt_q + WD_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      rr_ptr_q  <= '0;
      wd_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      rr_ptr_q  <= rr_ptr_d;
      wd_cnt_q  <= wd_cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign grant_idx    = grant_q;
  assign busy         = locked_c;
  assign timeout_indi = timeout_q;

endmodule

// File: tb/tb_avalon_st_packet_arbiter.sv
// Randomized and directed bench for avalon_st_packet_arbiter against a queue-based source/arbiter model.
module tb_avalon_st_packet_arbiter;
  localparam int NS = 4;
  localparam int DW = 16;
  localparam int TO = 8;
  localparam int EW = 4;
  localparam int DB = 128;

  typedef struct packed {
    logic          sop;
    logic          eop;
    logic [EW-1:0] empty;
    logic [DB-1:0] data;
  } beat_t;

  typedef struct {
    int    cyc;
    int    src;
    beat_t b;
  } obs_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic out_rdy = 1'b0;
  logic [NS-1:0] src_valid, src_sop, src_eop, src_rdy;
  logic [EW-1:0] src_empty [NS];
  logic [DB-1:0] src_data  [NS];
  logic [1:0]    grant_idx;
  logic          busy, timeout_indi;

  always #5 clk = ~clk;

  avalon_st_if #(.DATA_WIDTH_IN_BYTES(DW)) in_if [NS] ();
  avalon_st_if #(.DATA_WIDTH_IN_BYTES(DW)) out_if ();

  for (genvar gi = 0; gi < NS; gi++) begin : g_src
    assign in_if[gi].valid = src_valid[gi];
    assign in_if[gi].sop   = src_sop[gi];
    assign in_if[gi].eop   = src_eop[gi];
    assign in_if[gi].empty = src_empty[gi];
    assign in_if[gi].data  = src_data[gi];
    assign src_rdy[gi]     = in_if[gi].rdy;
  end
  assign out_if.rdy = out_rdy;

  avalon_st_packet_arbiter #(
    .NUM_SOURCES(NS), .DATA_WIDTH_IN_BYTES(DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst), .in_msg(in_if), .out_msg(out_if),
    .grant_idx(grant_idx), .busy(busy), .timeout_indi(timeout_indi)
  );

  beat_t q [NS][$];
  obs_t  obs [$];
  int    to_q [$];
  int    gap_pct = 0;
  int    cyc = 0;
  int    total = 0;
  int    bad = 0;
  int    c0;
  logic [DB-1:0] last_d0;

  // Model: which source owns the output, whose turn is next, and how long the owner has stalled.
  bit m_locked = 0;
  int m_g = 0;
  int m_ptr = 0;
  int m_wd = 0;
  bit m_to = 0;

  bit s_valid, s_busy, s_to;
  int s_grant;

  task automatic chk(input string name, input logic [DB-1:0] got, input logic [DB-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, got, exp);
    end
  endtask

  task automatic push_pkt(input int s, input int n, input logic [EW-1:0] emp);
    beat_t bt;
    for (int b = 0; b < n; b++) begin
      bt.sop   = (b == 0);
      bt.eop   = (b == n - 1);
      bt.empty = (b == n - 1) ? emp : '0;
      bt.data  = {$urandom(), $urandom(), $urandom(), $urandom()};
      if (b == 0) last_d0 = bt.data;
      q[s].push_back(bt);
    end
  endtask

  task automatic drive_inputs();
    for (int i = 0; i < NS; i++) begin
      if (q[i].size() > 0 && int'($urandom_range(99, 0)) >= gap_pct) begin
        src_valid[i] = 1'b1;
        src_sop[i]   = q[i][0].sop;
        src_eop[i]   = q[i][0].eop;
        src_empty[i] = q[i][0].empty;
        src_data[i]  = q[i][0].data;
      end else begin
        src_valid[i] = 1'b0;
        src_sop[i]   = 1'b0;
        src_eop[i]   = 1'b0;
        src_empty[i] = '0;
        src_data[i]  = '0;
      end
    end
  endtask

  task automatic check_and_advance();
    bit ev, found, e;
    obs_t o;
    ev = m_locked && src_valid[m_g];
    chk("out_valid", out_if.valid, ev);
    chk("busy", busy, m_locked);
    chk("grant_idx", grant_idx, m_g);
    chk("timeout_indi", timeout_indi, m_to);
    for (int i = 0; i < NS; i++) chk("src_rdy", src_rdy[i], m_locked && i == m_g && out_rdy);
    if (ev) begin
      chk("out_sop", out_if.sop, q[m_g][0].sop);
      chk("out_eop", out_if.eop, q[m_g][0].eop);
      chk("out_empty", out_if.empty, q[m_g][0].empty);
      chk("out_data", out_if.data, q[m_g][0].data);
    end
    s_valid = out_if.valid; s_busy = busy; s_to = timeout_indi; s_grant = int'(grant_idx);
    if (out_if.valid && out_rdy) begin
      o.cyc = cyc; o.src = int'(grant_idx);
      o.b = {out_if.sop, out_if.eop, out_if.empty, out_if.data};
      obs.push_back(o);
    end
    if (timeout_indi) to_q.push_back(cyc);
    // Advance the model to what the next clock edge must produce.
    if (rst) begin
      m_locked = 0; m_g = 0; m_ptr = 0; m_wd = 0; m_to = 0;
      for (int i = 0; i < NS; i++) q[i].delete();
    end else if (!m_locked) begin
      m_to = 0; found = 0;
      for (int k = 0; k < NS; k++) begin
        int i;
        i = (m_ptr + k) % NS;
        if (!found && src_valid[i] && src_sop[i]) begin
          found = 1; m_locked = 1; m_g = i; m_wd = 0;
        end
      end
    end else begin
      m_to = 0;
      if (src_valid[m_g] && out_rdy) begin
        e = q[m_g][0].eop;
        void'(q[m_g].pop_front());
        m_wd = 0;
        if (e) begin m_locked = 0; m_ptr = (m_g + 1) % NS; end
      end else if (m_wd == TO - 1) begin
        m_locked = 0; m_ptr = (m_g + 1) % NS; m_to = 1; m_wd = 0;
        while (q[m_g].size() > 0 && !q[m_g][0].sop) void'(q[m_g].pop_front());
      end else begin
        m_wd++;
      end
    end
  endtask

  task automatic cycle();
    drive_inputs();
    @(negedge clk);
    check_and_advance();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    obs.delete();
    to_q.delete();
  endtask

  initial begin
    src_valid = '0; src_sop = '0; src_eop = '0;
    for (int i = 0; i < NS; i++) begin src_empty[i] = '0; src_data[i] = '0; end
    @(posedge clk);
    #1;
    run(2);
    rst = 1'b0;
    out_rdy = 1'b1;

    // 3-beat packet on source 2 with empty=5 on eop.
    push_pkt(2, 3, 4'd5);
    c0 = cyc;
    cycle();
    chk("t1_arb_busy", s_busy, 1'b0);
    cycle();
    chk("t1_grant", s_grant, 2);
    chk("t1_first_valid", s_valid, 1'b1);
    run(2);
    cycle();
    chk("t1_busy_after_eop", s_busy, 1'b0);
    chk("t1_beats", obs.size(), 3);
    chk("t1_data0", obs[0].b.data, last_d0);
    chk("t1_empty", obs[2].b.empty, 4'd5);
    chk("t1_eop_cyc", obs[2].cyc, c0 + 3);
    // rr_ptr is now 3: source 3 must beat source 0.
    push_pkt(0, 1, '0);
    push_pkt(3, 1, '0);
    run(6);
    chk("t1_ptr3_first", obs[3].src, 3);
    chk("t1_ptr3_second", obs[4].src, 0);

    // All sources with back-to-back 2-beat packets.
    do_reset();
    for (int s = 0; s < NS; s++) push_pkt(s, 2, 4'(s));
    push_pkt(0, 2, '0);
    run(20);
    chk("t2_beats", obs.size(), 10);
    for (int p = 0; p < 5; p++) begin
      chk("t2_order", obs[2*p].src, p % NS);
      chk("t2_back2back", obs[2*p+1].cyc, obs[2*p].cyc + 1);
      if (p > 0) chk("t2_gap", obs[2*p].cyc, obs[2*p-1].cyc + 2);
    end

    // Sources 1 and 3 with rr_ptr=2.
    do_reset();
    push_pkt(1, 1, '0);
    run(4);
    obs.delete();
    push_pkt(1, 1, '0);
    push_pkt(3, 1, '0);
    run(6);
    chk("t3_first", obs[0].src, 3);
    chk("t3_second", obs[1].src, 1);

    // Single-beat packets on sources 0 and 1.
    do_reset();
    c0 = cyc;
    push_pkt(0, 1, 4'd1);
    push_pkt(1, 1, 4'd2);
    run(6);
    chk("t4_count", obs.size(), 2);
    chk("t4_cyc0", obs[0].cyc, c0 + 1);
    chk("t4_cyc1", obs[1].cyc, c0 + 3);
    chk("t4_src1", obs[1].src, 1);

    // Watchdog: source 0 stalls after sop, source 1 waits.
    do_reset();
    c0 = cyc;
    q[0].push_back('{sop: 1'b1, eop: 1'b0, empty: '0, data: DB'(128'hABCD)});
    push_pkt(1, 1, '0);
    run(16);
    chk("t5_to_count", to_q.size(), 1);
    chk("t5_to_cyc", to_q[0], c0 + 10);
    chk("t5_next_src", obs[1].src, 1);
    chk("t5_next_cyc", obs[1].cyc, c0 + 11);

    // Reset in the middle of a 5-beat packet.
    do_reset();
    push_pkt(2, 5, '0);
    run(3);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    cycle();
    chk("t6_valid", s_valid, 1'b0);
    chk("t6_busy", s_busy, 1'b0);
    chk("t6_grant", s_grant, 0);
    obs.delete();
    c0 = cyc;
    push_pkt(0, 1, '0);
    run(3);
    chk("t6_fresh_src", obs[0].src, 0);
    chk("t6_fresh_cyc", obs[0].cyc, c0 + 1);

    // Random traffic with source gaps and output backpressure.
    do_reset();
    gap_pct = 15;
    for (int k = 0; k < 3000; k++) begin
      for (int s = 0; s < NS; s++)
        if (q[s].size() == 0 && $urandom_range(3, 0) == 0)
          push_pkt(s, int'($urandom_range(5, 1)), EW'($urandom_range(15, 0)));
      out_rdy = ($urandom_range(3, 0) != 0);
      cycle();
    end
    gap_pct = 0;
    out_rdy = 1'b1;
    run(60);
    for (int s = 0; s < NS; s++) chk("drain_empty", q[s].size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
